seq_gen: RTL and testbench

Parametrised recurrence-sequence generator; the next generation of the single-purpose Fibonacci engine. It adds a selectable recurrence mode (Fibonacci, Pell, Jacobsthal, Tribonacci), configurable data and index widths, and a start/busy/done control handshake. Terms stream out over a valid/ready interface with backpressure, and arithmetic overflow is detected. It sits beside the CPU datapath as a memory-mapped accelerator; software seeds it and drains the terms.

---
 rtl/seq_gen_pkg.sv | 21 ++
 rtl/seq_next_term.sv | 50 +++++
 rtl/seq_gen.sv | 153 +++++++++++++++
 tb/tb_seq_gen.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the seq_gen recurrence generator: mode and state
// encodings plus the carry headroom used by the next-term arithmetic.
package seq_gen_pkg;

    // Extra bits above W needed to hold the largest recurrence sum (3 * max term)
    localparam int CARRY_W = 2;

    typedef enum logic [1:0] {
        MODE_FIB   = 2'd0,
        MODE_PELL  = 2'd1,
        MODE_JACOB = 2'd2,
        MODE_TRIB  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_next_term.sv
// Combinational next-term unit for seq_gen. Computes the recurrence in
// W+CARRY_W bits and flags any carry out of the W-bit result.
// Optional macro SEQ_GEN_SAT_EN: an overflowing result saturates to all-ones
// instead of wrapping. Because every recurrence weights t2 by at least one,
// a saturated t2 keeps all later terms saturated without extra state.
module seq_next_term
    import seq_gen_pkg::*;
#(
    parameter int W = 16
) (
    input  mode_e          mode_i,
    input  logic [W-1:0]   t0_i,
    input  logic [W-1:0]   t1_i,
    input  logic [W-1:0]   t2_i,
    output logic [W-1:0]   next_o,
    output logic           ovf_o
);

    localparam int SW = W + CARRY_W;

    logic [SW-1:0] t0_x;
    logic [SW-1:0] t1_x;
    logic [SW-1:0] t2_x;
    logic [SW-1:0] sum_d;

    assign t0_x = SW'(t0_i);
    assign t1_x = SW'(t1_i);
    assign t2_x = SW'(t2_i);

    // Full-width recurrence sum selected by mode
    always_comb begin
        sum_d = '0;
        case (mode_i)
            MODE_FIB:   sum_d = t1_x + t2_x;
            MODE_PELL:  sum_d = (t2_x << 1) + t1_x;
            MODE_JACOB: sum_d = t2_x + (t1_x << 1);
            MODE_TRIB:  sum_d = t0_x + t1_x + t2_x;
            default:    sum_d = '0;
        endcase
    end

    assign ovf_o = |sum_d[SW-1:W];

`ifdef SEQ_GEN_SAT_EN
    assign next_o = ovf_o ? {W{1'b1}} : sum_d[W-1:0];
`else
    assign next_o = sum_d[W-1:0];
`endif

endmodule

// File: rtl/seq_gen.sv
// Recurrence-sequence generator (Fibonacci, Pell, Jacobsthal, Tribonacci).
// Software seeds three terms and an index range; terms stream out on a
// valid/ready interface, one per cycle while the consumer is ready.
// Optional macro SEQ_GEN_SAT_EN (handled in seq_next_term): saturate on
// overflow instead of wrapping.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int W  = 16,
    parameter int IW = 12
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  seed0,
    input  logic [W-1:0]  seed1,
    input  logic [W-1:0]  seed2,
    input  logic [IW-1:0] start_idx,
    input  logic [IW-1:0] target_idx,
    output logic          term_valid,
    input  logic          term_ready,
    output logic [W-1:0]  term,
    output logic [IW-1:0] term_idx,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          overflow
);

    state_e        state_q;
    mode_e         mode_q;
    logic [W-1:0]  t0_q;
    logic [W-1:0]  t1_q;
    logic [W-1:0]  t2_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] target_q;
    logic          term_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          overflow_q;

    logic [W-1:0]  next_term_d;
    logic          next_ovf_d;
    logic          handshake_d;
    logic          last_term_d;

    seq_next_term #(
        .W (W)
    ) u_next (
        .mode_i (mode_q),
        .t0_i   (t0_q),
        .t1_i   (t1_q),
        .t2_i   (t2_q),
        .next_o (next_term_d),
        .ovf_o  (next_ovf_d)
    );

    assign handshake_d = term_valid_q & term_ready;
    assign last_term_d = (idx_q == target_q);

    // Control FSM, term shift register and status flags
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_FIB;
            t0_q         <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            idx_q        <= '0;
            target_q     <= '0;
            term_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (abort) begin
            // Abort discards everything and returns all outputs to idle values
            state_q      <= ST_IDLE;
            t0_q         <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            idx_q        <= '0;
            term_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q     <= mode_e'(mode);
                        t0_q       <= seed0;
                        t1_q       <= seed1;
                        t2_q       <= seed2;
                        idx_q      <= start_idx;
                        target_q   <= target_idx;
                        overflow_q <= 1'b0;
                        if (target_idx < start_idx) begin
                            // Empty range: report the error, emit nothing
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            err_q        <= 1'b1;
                            busy_q       <= 1'b0;
                            term_valid_q <= 1'b0;
                        end else begin
                            state_q      <= ST_RUN;
                            done_q       <= 1'b0;
                            err_q        <= 1'b0;
                            busy_q       <= 1'b1;
                            term_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (handshake_d) begin
                        if (last_term_d) begin
                            state_q      <= ST_DONE;
                            term_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            t0_q       <= t1_q;
                            t1_q       <= t2_q;
                            t2_q       <= next_term_d;
                            idx_q      <= idx_q + IW'(1);
                            overflow_q <= overflow_q | next_ovf_d;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    term_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                end
            endcase
        end
    end

    assign term_valid = term_valid_q;
    assign term       = t2_q;
    assign term_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed runs from the test plan plus
// randomized runs, all checked against an arithmetic sequence model.
module tb_seq_gen;

    localparam int W    = 16;
    localparam int IW   = 12;
    localparam longint MAXV = (longint'(1) << W) - 1;
    localparam int MAXC = 2000;

    logic          CLK;
    logic          reset;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [W-1:0]  seed0;
    logic [W-1:0]  seed1;
    logic [W-1:0]  seed2;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] target_idx;
    logic          term_valid;
    logic          term_ready;
    logic [W-1:0]  term;
    logic [IW-1:0] term_idx;
    logic          busy;
    logic          done;
    logic          err;
    logic          overflow;

    int n_cmp = 0;
    int n_mis = 0;

    // Observed values of the last accepted term in the most recent run
    longint last_term;
    longint last_idx;
    longint last_ovf;
    // Observed term at a particular index (for directed constant checks)
    longint probe_idx;
    longint probe_term;
    longint probe_ovf;

    seq_gen #(
        .W  (W),
        .IW (IW)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .seed0      (seed0),
        .seed1      (seed1),
        .seed2      (seed2),
        .start_idx  (start_idx),
        .target_idx (target_idx),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term       (term),
        .term_idx   (term_idx),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .overflow   (overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, term_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_ovf"},   overflow, 0);
        check({tag, "_term"},  term, 0);
        check({tag, "_idx"},   term_idx, 0);
    endtask

    // Apply a next-term rule to three consecutive terms (oldest first)
    function automatic longint rule(input int md, input longint a, input longint b, input longint c);
        case (md)
            0:       return b + c;
            1:       return 2 * c + b;
            2:       return c + 2 * b;
            default: return a + b + c;
        endcase
    endfunction

    // One run: kill=0 none, 1 abort(+start) when term kill_k shown, 2 reset then.
    // rpol: 0 ready always, 1 random ready plus stray starts, 2 stall 3 cycles at k=3.
    task automatic run(input int md, input longint s0, input longint s1, input longint s2,
                       input int sidx, input int tidx, input int rpol,
                       input int kill, input int kill_k);
        longint v[$];
        bit     ov[$];
        bit     sticky;
        longint nxt;
        int     n;
        int     k;
        int     cyc;
        int     stall;
        bit     rdy;

        // Model: terms by index, sticky overflow as seen alongside each term
        v.delete();
        ov.delete();
        v.push_back(s0);
        v.push_back(s1);
        v.push_back(s2);
        sticky = 0;
        n = tidx - sidx + 1;
        for (int i = 0; i < n; i++) begin
            ov.push_back(sticky);
            if (i < n - 1) begin
                nxt = rule(md, v[i], v[i+1], v[i+2]);
                if (nxt > MAXV) begin
                    sticky = 1;
`ifdef SEQ_GEN_SAT_EN
                    nxt = MAXV;
`else
                    nxt = nxt & MAXV;
`endif
                end
                v.push_back(nxt);
            end
        end

        start      = 1'b1;
        mode       = 2'(md);
        seed0      = W'(s0);
        seed1      = W'(s1);
        seed2      = W'(s2);
        start_idx  = IW'(sidx);
        target_idx = IW'(tidx);
        @(negedge CLK);
        start = 1'b0;
        // Scramble the configuration inputs; the run must use captured values
        mode       = 2'($urandom_range(0, 3));
        seed0      = W'($urandom);
        seed1      = W'($urandom);
        seed2      = W'($urandom);
        start_idx  = IW'($urandom);
        target_idx = IW'($urandom);

        if (tidx < sidx) begin
            check("err_done",  done, 1);
            check("err_err",   err, 1);
            check("err_valid", term_valid, 0);
            check("err_busy",  busy, 0);
            $display("run mode=%0d idx %0d..%0d -> err", md, sidx, tidx);
            return;
        end

        k = 0;
        cyc = 0;
        stall = 0;
        while (k < n && cyc < MAXC) begin
            check("valid", term_valid, 1);
            check("busy",  busy, 1);
            check("term",  term, v[k+2]);
            check("idx",   term_idx, sidx + k);
            check("ovf",   overflow, ov[k]);
            if (longint'(term_idx) == probe_idx) begin
                probe_term = term;
                probe_ovf  = overflow;
            end
            if (kill != 0 && k == kill_k) begin
                if (kill == 1) begin
                    abort = 1'b1;
                    start = 1'b1;
                    @(negedge CLK);
                    abort = 1'b0;
                    start = 1'b0;
                    check_idle("abort");
                    @(negedge CLK);
                    check("abort_stay", term_valid, 0);
                end else begin
                    reset = 1'b0;
                    #1;
                    check_idle("rst");
                    @(negedge CLK);
                    reset = 1'b1;
                end
                $display("run mode=%0d idx %0d..%0d killed(%0d) at idx %0d", md, sidx, tidx, kill, sidx + k);
                return;
            end
            case (rpol)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    if (k == 3 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            term_ready = rdy;
            if (rpol == 1 && $urandom_range(0, 4) == 0) start = 1'b1;
            last_term = term;
            last_idx  = term_idx;
            last_ovf  = overflow;
            @(negedge CLK);
            term_ready = 1'b0;
            start = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        check("no_timeout", cyc < MAXC, 1);
        check("end_done",  done, 1);
        check("end_busy",  busy, 0);
        check("end_valid", term_valid, 0);
        check("end_err",   err, 0);
        check("end_ovf",   overflow, sticky);
        $display("run mode=%0d idx %0d..%0d terms=%0d cycles=%0d last=%0d ovf=%0d",
                 md, sidx, tidx, n, cyc, last_term, overflow);
    endtask

    initial begin
        int md;
        int sidx;
        int tidx;
        longint s0;
        longint s1;
        longint s2;

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode = '0;
        seed0 = '0;
        seed1 = '0;
        seed2 = '0;
        start_idx = '0;
        target_idx = '0;
        term_ready = 1'b0;
        probe_idx = -1;
        probe_term = 0;
        probe_ovf = 0;
        repeat (2) @(negedge CLK);
        check_idle("reset");
        reset = 1'b1;
        @(negedge CLK);

        // Fibonacci 1..10, full throughput
        run(0, 0, 0, 1, 1, 10, 0, 0, 0);
        check("fib10_last", last_term, 55);
        check("fib10_idx",  last_idx, 10);

        // Pell and Tribonacci
        run(1, 0, 0, 1, 1, 6, 0, 0, 0);
        check("pell6_last", last_term, 70);
        run(3, 0, 0, 1, 2, 7, 0, 0, 0);
        check("trib7_last", last_term, 13);

        // Fibonacci to 25: overflow boundary
        probe_idx = 24;
        run(0, 0, 0, 1, 1, 25, 0, 0, 0);
        check("fib24_term", probe_term, 46368);
        check("fib24_ovf",  probe_ovf, 0);
`ifdef SEQ_GEN_SAT_EN
        check("fib25_term", last_term, 65535);
`else
        check("fib25_term", last_term, 9489);
`endif
        check("fib25_ovf", last_ovf, 1);
        probe_idx = -1;

        // Backpressure: stall three cycles while idx 4 is shown
        probe_idx = 4;
        run(0, 0, 0, 1, 1, 10, 2, 0, 0);
        check("bp_term4", probe_term, 3);
        probe_idx = -1;

        // Empty range
        run(0, 0, 0, 1, 5, 3, 0, 0, 0);

        // Abort with start while in DONE
        abort = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        start = 1'b0;
        check_idle("done_abort");

        // Abort an overflowed run at idx 25, then a fresh run must start clean
        run(0, 0, 0, 1, 1, 30, 0, 1, 24);
        run(0, 0, 0, 1, 1, 10, 0, 0, 0);
        // Abort at idx 6
        run(0, 0, 0, 1, 1, 10, 0, 1, 5);
        // Reset mid-run, then fresh run
        run(1, 0, 0, 1, 1, 10, 1, 2, 4);
        run(2, 0, 0, 1, 0, 8, 1, 0, 0);

        // Top of the index range, single-term run
        run(3, 5, 6, 7, 4090, 4095, 0, 0, 0);
        run(0, 3, 4, 5, 17, 17, 0, 0, 0);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            md = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                s0 = $urandom_range(0, 3);
                s1 = $urandom_range(0, 3);
                s2 = $urandom_range(0, 3);
            end else begin
                s0 = $urandom_range(0, 65535);
                s1 = $urandom_range(0, 65535);
                s2 = $urandom_range(0, 65535);
            end
            sidx = $urandom_range(1, 60);
            if ($urandom_range(0, 7) == 0) tidx = sidx - $urandom_range(1, sidx);
            else tidx = sidx + $urandom_range(0, 20);
            run(md, s0, s1, s2, sidx, tidx, $urandom_range(0, 1), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
